// File: rtl/instr_fetch_queue.sv
// Purpose : sequential instruction fetcher feeding a DEPTH-entry {pc, code} queue
//           from a combinational ROM; flushes on redirect and stops at HALT_PC.
// Latency : an address presented on rom_addr appears at the queue head one cycle later.
// Backpr. : fetching stalls while the queue holds DEPTH entries; the head holds
//           while instr_ready is low.
// Ports   : clk/reset (sync, active-high); rom_addr/rom_data ROM port;
//           instr_out/instr_pc/instr_valid/instr_ready decoder handshake;
//           redirect_en/redirect_target branch flush; fetch_done halted-and-drained.
// Option  : `define FETCH_PERF_EN adds fetch_count (pushes, 16b) and
//           flush_count (redirects, 8b), both saturating.
module instr_fetch_queue #(
  parameter int D       = 12,
  parameter int W       = 9,
  parameter int DEPTH   = 4,
  parameter int HALT_PC = 12
) (
  input  logic         clk,
  input  logic         reset,
  output logic [D-1:0] rom_addr,
  input  logic [W-1:0] rom_data,
  output logic [W-1:0] instr_out,
  output logic [D-1:0] instr_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         redirect_en,
  input  logic [D-1:0] redirect_target,
  output logic         fetch_done
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]  fetch_count,
  output logic [7:0]   flush_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [D-1:0]  HALT_C  = D'(HALT_PC);

  typedef struct packed {
    logic [D-1:0] pc;
    logic [W-1:0] code;
  } entry_t;

  // FULL and HALT are mutually exclusive by priority: once halted the queue
  // only drains, so HALT is reported even if the queue happens to be full.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_FULL  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [D-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic           fetch_done_q, fetch_done_d;
  entry_t         mem_q [DEPTH];

  logic           halted;
  logic           push_opp;
  logic           push;
  logic           pop;
  logic           halted_d;

  assign halted      = (state_q == S_HALT);
  assign rom_addr    = fetch_pc_q;
  assign instr_valid = (count_q != '0) && !redirect_en;
  assign instr_out   = mem_q[rd_ptr_q].code;
  assign instr_pc    = mem_q[rd_ptr_q].pc;
  assign fetch_done  = fetch_done_q;

  // S_FETCH already encodes "not halted and count < DEPTH" from cycle start,
  // so a pop in this cycle cannot open a slot for a push at DEPTH.
  assign push_opp = (state_q == S_FETCH) && !redirect_en;
  assign push     = push_opp && (fetch_pc_q != HALT_C);
  assign pop      = instr_valid && instr_ready;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    halted_d     = halted || (push_opp && (fetch_pc_q == HALT_C));
    fetch_done_d = halted && (count_q == '0) && !redirect_en;

    if (push) begin
      fetch_pc_d = fetch_pc_q + D'(1);
      wr_ptr_d   = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (redirect_en) begin
      fetch_pc_d = redirect_target;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      halted_d   = 1'b0;
    end

    if (halted_d) begin
      state_d = S_HALT;
    end else if (count_d == DEPTH_C) begin
      state_d = S_FULL;
    end else begin
      state_d = S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      fetch_pc_q   <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fetch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fetch_done_q <= fetch_done_d;
    end
  end

  // Storage carries no reset; entries are only observable once counted.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= '{pc: fetch_pc_q, code: rom_data};
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [7:0]  flush_count_q, flush_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    flush_count_d = flush_count_q;
    if (push && (fetch_count_q != 16'hFFFF)) fetch_count_d = fetch_count_q + 16'd1;
    if (redirect_en && (flush_count_q != 8'hFF)) flush_count_d = flush_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Purpose : self-checking bench for instr_fetch_queue with a queue-based reference model.
// Latency : model and DUT are compared every falling edge outside reset.
// Backpr. : stimulus drives instr_ready patterns directly.
module tb_instr_fetch_queue;
  localparam int D       = 12;
  localparam int W       = 9;
  localparam int DEPTH   = 4;
  localparam int HALT_PC = 12;
  localparam logic [D-1:0] HALT_C = D'(HALT_PC);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [D-1:0] rom_addr;
  logic [W-1:0] rom_data;
  logic [W-1:0] instr_out;
  logic [D-1:0] instr_pc;
  logic         instr_valid;
  logic         rdy = 1'b0;
  logic         redir = 1'b0;
  logic [D-1:0] tgt = '0;
  logic         fetch_done;
`ifdef FETCH_PERF_EN
  logic [15:0]  fetch_count;
  logic [7:0]   flush_count;
`endif

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rom_fn(input logic [D-1:0] a);
    return a[W-1:0] + 9'h100;
  endfunction

  always_comb rom_data = rom_fn(rom_addr);

  instr_fetch_queue #(.D(D), .W(W), .DEPTH(DEPTH), .HALT_PC(HALT_PC)) dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(rdy), .redirect_en(redir), .redirect_target(tgt),
    .fetch_done(fetch_done)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Reference model: a plain queue of {pc, code} plus fetch pointer and halt flag.
  logic [D+W-1:0] mq[$];
  logic [D-1:0]   mpc = '0;
  bit             mhalt = 1'b0;
  bit             mdone = 1'b0;
  int             mfetch = 0;
  int             mflush = 0;
  int             acc[$];

  always @(posedge clk) begin
    bit vld, full, dn;
    if (reset) begin
      mq.delete();
      mpc = '0; mhalt = 1'b0; mdone = 1'b0; mfetch = 0; mflush = 0;
    end else begin
      if (instr_valid && rdy) acc.push_back(int'(instr_pc));
      vld = (mq.size() > 0) && !redir;
      dn  = mhalt && (mq.size() == 0) && !redir;
      if (redir) begin
        mq.delete();
        mpc = tgt;
        mhalt = 1'b0;
        if (mflush < 255) mflush++;
      end else begin
        full = (mq.size() == DEPTH);
        if (vld && rdy) void'(mq.pop_front());
        if (!mhalt && !full) begin
          if (mpc == HALT_C) mhalt = 1'b1;
          else begin
            mq.push_back({mpc, rom_fn(mpc)});
            mpc = mpc + D'(1);
            if (mfetch < 65535) mfetch++;
          end
        end
      end
      mdone = dn;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("rom_addr", rom_addr, mpc);
      check("instr_valid", instr_valid, (mq.size() > 0) && !redir);
      if ((mq.size() > 0) && !redir) begin
        check("instr_pc", instr_pc, mq[0][D+W-1:W]);
        check("instr_out", instr_out, mq[0][W-1:0]);
      end
      check("fetch_done", fetch_done, mdone);
`ifdef FETCH_PERF_EN
      check("fetch_count", fetch_count, mfetch);
      check("flush_count", flush_count, mflush);
`endif
    end
  end

  task automatic do_reset(input bit r);
    @(posedge clk); #1;
    reset = 1'b1; redir = 1'b0; rdy = r;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Streaming from reset with the decoder always ready, running into the halt.
    rdy = 1'b1; reset = 1'b0; acc.delete();
    @(negedge clk); check("t1_valid_cycle1", instr_valid, 0);
    @(negedge clk); check("t1_valid_cycle2", instr_valid, 1);
    check("t1_pc_cycle2", instr_pc, 0);
    check("t1_code_cycle2", instr_out, 9'h100);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t1_count", acc.size(), 12);
    for (int i = 0; i < 12; i++) check("t1_seq", (i < acc.size()) ? acc[i] : -1, i);
    check("t1_done", fetch_done, 1);
    check("t1_addr_halt", rom_addr, 12);

    // Stalled decoder fills the queue, then drains without bubbles.
    do_reset(1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("t2_addr_full", rom_addr, 4);
    check("t2_head_pc", instr_pc, 0);
    check("t2_valid", instr_valid, 1);
    @(posedge clk); #1;
    acc.delete(); rdy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t2_drain_count", acc.size(), 5);
    for (int i = 0; i < 5; i++) check("t2_drain_seq", (i < acc.size()) ? acc[i] : -1, i);

    // Redirect with pcs 3..6 queued.
    do_reset(1'b0);
    repeat (8) @(posedge clk);
    #1; rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1; rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t3_head_pc", instr_pc, 3);
    check("t3_addr", rom_addr, 7);
    @(posedge clk); #1;
    acc.delete(); redir = 1'b1; tgt = 12'd9; rdy = 1'b1;
    @(negedge clk); check("t3_valid_redir", instr_valid, 0);
    @(posedge clk); #1; redir = 1'b0;
    @(negedge clk); check("t3_valid_plus1", instr_valid, 0);
    @(negedge clk);
    check("t3_valid_plus2", instr_valid, 1);
    check("t3_pc_plus2", instr_pc, 9);
    repeat (2) @(posedge clk);
    #1;
    check("t3_first_acc", (acc.size() > 0) ? acc[0] : -1, 9);

    // Halt, then redirect back into the program.
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t4_done", fetch_done, 1);
    check("t4_addr", rom_addr, 12);
    @(posedge clk); #1;
    acc.delete(); redir = 1'b1; tgt = 12'd2;
    @(negedge clk); check("t4_done_redir_cycle", fetch_done, 1);
    @(posedge clk); #1; redir = 1'b0;
    @(negedge clk);
    check("t4_done_dropped", fetch_done, 0);
    check("t4_addr_resume", rom_addr, 2);
    repeat (3) @(posedge clk);
    #1;
    check("t4_first_acc", (acc.size() > 0) ? acc[0] : -1, 2);

    // Redirect straight to the halt address re-halts without fetching.
    @(posedge clk); #1; redir = 1'b1; tgt = HALT_C;
    @(posedge clk); #1; redir = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t4b_done", fetch_done, 1);
    check("t4b_valid", instr_valid, 0);
    check("t4b_addr", rom_addr, 12);

    // Reset beats a concurrent redirect with entries queued.
    do_reset(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); check("t5_valid_pre", instr_valid, 1);
    @(posedge clk); #1;
    reset = 1'b1; redir = 1'b1; tgt = 12'd5; rdy = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; redir = 1'b0; rdy = 1'b0;
    @(negedge clk);
    check("t5_valid_post", instr_valid, 0);
    check("t5_addr_post", rom_addr, 0);
    @(negedge clk);
    check("t5_first_pc", instr_pc, 0);

`ifdef FETCH_PERF_EN
    do_reset(1'b1);
    tgt = '0;
    repeat (10) @(posedge clk);
    #1; redir = 1'b1;
    @(posedge clk); #1; redir = 1'b0;
    repeat (10) @(posedge clk);
    #1; redir = 1'b1;
    @(posedge clk); #1; redir = 1'b0;
    @(negedge clk);
    check("perf_fetch_20", fetch_count, 20);
    check("perf_flush_2", flush_count, 2);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
